ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4...) to a PS/2 keyboard or mouse.

---
 rtl/ps2_host_tx_pkg.sv | 33 +++
 rtl/ps2_host_tx_if.sv | 26 ++
 rtl/ps2_host_tx_line_filter.sv | 52 +++++
 rtl/ps2_host_tx.sv | 175 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host definitions: transmitter state encoding, error codes and
// small constant helpers. Receivers on the same pins import this as well.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StAck,
    StWaitIdle,
    StDone,
    StError
  } state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ErrNone   = 2'b00;
  localparam err_code_t ErrStart  = 2'b01;
  localparam err_code_t ErrPacket = 2'b10;
  localparam err_code_t ErrNoAck  = 2'b11;

  // Microseconds to system clock cycles; integer MHz clocks assumed.
  function automatic int unsigned us_to_cyc(input int unsigned hz, input int unsigned us);
    return (hz / 32'd1_000_000) * us;
  endfunction

  // Odd parity bit appended after the data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a requester (master) and the PS/2 host
// transmitter (slave).
//   tx_valid/tx_data : request and byte, accepted when tx_valid & tx_ready
//   tx_done/tx_error : one-cycle completion pulses, err_code valid with tx_error
//   busy             : a transmission owns the PS/2 bus
interface ps2_host_tx_if;
  import ps2_host_tx_pkg::*;

  logic      tx_valid;
  logic [7:0] tx_data;
  logic      tx_ready;
  logic      tx_done;
  logic      tx_error;
  err_code_t err_code;
  logic      busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, tx_error, err_code, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, tx_error, err_code, busy
  );
endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// PS/2 line input conditioning: 2-flop synchroniser followed by a glitch
// filter. The filtered level moves only after FILTER_LEN consecutive
// synchronised samples disagree with it; fall_o pulses for one cycle when the
// filtered level goes 1->0.
//   clk, rst : system clock, asynchronous active-high reset
//   line_i   : raw pin level (asynchronous)
//   level_o  : filtered level (resets high, the idle bus level)
//   fall_o   : one-cycle falling-edge event
module ps2_host_tx_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

  logic [1:0]      sync_q;
  logic            level_q;
  logic            fall_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        // FILTER_LEN-th disagreeing sample: accept the new level.
        level_q <= sync_q[1];
        fall_q  <= level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues request-to-send,
// shifts out one command byte (LSB first, odd parity, stop) on device-driven
// clock edges and checks the device ACK.
//   clk, rst               : system clock, asynchronous active-high reset
//   tx_if (slave)          : command handshake, completion pulses, busy
//   ps2clk_in, ps2data_in  : pin levels (asynchronous)
//   ps2clk_oe, ps2data_oe  : 1 pulls the open-drain pin low
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ            = 28_000_000,
  parameter int unsigned INHIBIT_US        = 120,
  parameter int unsigned START_TIMEOUT_US  = 15_000,
  parameter int unsigned PACKET_TIMEOUT_US = 2_000,
  parameter int unsigned FILTER_LEN        = 8
) (
  input  logic clk,
  input  logic rst,
  ps2_host_tx_if.slave tx_if,
  input  logic ps2clk_in,
  input  logic ps2data_in,
  output logic ps2clk_oe,
  output logic ps2data_oe
);

  localparam int unsigned InhCyc   = us_to_cyc(CLK_HZ, INHIBIT_US);
  localparam int unsigned StartCyc = us_to_cyc(CLK_HZ, START_TIMEOUT_US);
  localparam int unsigned PktCyc   = us_to_cyc(CLK_HZ, PACKET_TIMEOUT_US);
  localparam int unsigned MaxCyc   = (InhCyc > StartCyc) ?
                                     ((InhCyc > PktCyc) ? InhCyc : PktCyc) :
                                     ((StartCyc > PktCyc) ? StartCyc : PktCyc);
  localparam int unsigned TmrW     = $clog2(MaxCyc + 1);

  localparam logic [TmrW-1:0] InhPre    = TmrW'(InhCyc - 2);
  localparam logic [TmrW-1:0] InhLast   = TmrW'(InhCyc - 1);
  localparam logic [TmrW-1:0] StartLast = TmrW'(StartCyc - 1);
  localparam logic [TmrW-1:0] PktLast   = TmrW'(PktCyc - 1);

  logic clk_lvl, clk_fall, data_lvl, unused_data_fall;

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2clk_in),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2data_in),
    .level_o (data_lvl),
    .fall_o  (unused_data_fall)
  );

  state_e          state_q;
  logic [8:0]      shift_q;  // {parity, data}; shifts right, back-filled with stop (1)
  logic [3:0]      edge_q;   // device falling edges seen so far
  logic [TmrW-1:0] tmr_q;    // shared inhibit / start / packet timer
  logic            clk_oe_q, data_oe_q;
  logic            ready_q, busy_q, done_q, error_q;
  err_code_t       err_code_q;
  err_code_t       fail_code;

  // Failure detection; a non-zero code overrides the normal transition.
  always_comb begin
    fail_code = ErrNone;
    case (state_q)
      StReq: begin
        if (!clk_fall && tmr_q == StartLast) fail_code = ErrStart;
      end
      StShift, StWaitIdle: begin
        if (tmr_q == PktLast) fail_code = ErrPacket;
      end
      StAck: begin
        if (clk_fall && data_lvl) fail_code = ErrNoAck;
        else if (tmr_q == PktLast) fail_code = ErrPacket;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      edge_q     <= '0;
      tmr_q      <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      tmr_q   <= tmr_q + 1'b1;
      case (state_q)
        StIdle: begin
          tmr_q <= '0;
          if (tx_if.tx_valid) begin
            shift_q  <= {odd_parity(tx_if.tx_data), tx_if.tx_data};
            clk_oe_q <= 1'b1;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= StInhibit;
          end
        end
        StInhibit: begin
          // Start bit goes out during the final inhibit cycle.
          if (tmr_q == InhPre) data_oe_q <= 1'b1;
          if (tmr_q == InhLast) begin
            clk_oe_q <= 1'b0;
            tmr_q    <= '0;
            state_q  <= StReq;
          end
        end
        StReq: begin
          if (clk_fall) begin
            data_oe_q <= ~shift_q[0];
            shift_q   <= {1'b1, shift_q[8:1]};
            edge_q    <= 4'd1;
            tmr_q     <= '0;
            state_q   <= StShift;
          end
        end
        StShift: begin
          // Edges 2..10 drive data 1..7, parity, then the back-filled stop.
          if (clk_fall) begin
            data_oe_q <= ~shift_q[0];
            shift_q   <= {1'b1, shift_q[8:1]};
            edge_q    <= edge_q + 4'd1;
            if (edge_q == 4'd9) state_q <= StAck;
          end
        end
        StAck: begin
          if (clk_fall && !data_lvl) state_q <= StWaitIdle;
        end
        StWaitIdle: begin
          if (clk_lvl && data_lvl) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone, StError: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (fail_code != ErrNone) begin
        error_q    <= 1'b1;
        err_code_q <= fail_code;
        busy_q     <= 1'b0;
        clk_oe_q   <= 1'b0;
        data_oe_q  <= 1'b0;
        state_q    <= StError;
      end
    end
  end

  assign tx_if.tx_ready = ready_q;
  assign tx_if.tx_done  = done_q;
  assign tx_if.tx_error = error_q;
  assign tx_if.err_code = err_code_q;
  assign tx_if.busy     = busy_q;
  assign ps2clk_oe      = clk_oe_q;
  assign ps2data_oe     = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ            = 1_000_000;
  localparam int unsigned INHIBIT_US        = 120;
  localparam int unsigned START_TIMEOUT_US  = 15_000;
  localparam int unsigned PACKET_TIMEOUT_US = 2_000;
  localparam int unsigned FILTER_LEN        = 8;
  localparam int INH_CYC   = int'(CLK_HZ / 1_000_000 * INHIBIT_US);
  localparam int START_CYC = int'(CLK_HZ / 1_000_000 * START_TIMEOUT_US);
  localparam int HALF      = 40;  // 12.5 kHz device clock at 1 MHz

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if tx_if ();
  logic ps2clk_in, ps2data_in, ps2clk_oe, ps2data_oe;
  logic dev_clk = 1'b1, dev_data = 1'b1, dev_glitch = 1'b0;

  // Open-drain bus: either side may pull low.
  assign ps2clk_in  = ~ps2clk_oe & dev_clk & ~dev_glitch;
  assign ps2data_in = ~ps2data_oe & dev_data;

  ps2_host_tx #(
    .CLK_HZ            (CLK_HZ),
    .INHIBIT_US        (INHIBIT_US),
    .START_TIMEOUT_US  (START_TIMEOUT_US),
    .PACKET_TIMEOUT_US (PACKET_TIMEOUT_US),
    .FILTER_LEN        (FILTER_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_if      (tx_if.slave),
    .ps2clk_in  (ps2clk_in),
    .ps2data_in (ps2data_in),
    .ps2clk_oe  (ps2clk_oe),
    .ps2data_oe (ps2data_oe)
  );

  int errors = 0;
  int checks = 0;

  // Bus monitor, sampled on the inactive edge.
  int         cyc = 0, done_cnt = 0, err_cnt = 0, run_len = 0, inh_len = 0;
  int         rel_cyc = 0, err_cyc = 0;
  logic [1:0] err_oe = 2'b00, last_code = 2'b00;
  logic       err_d1 = 1'b0, ready_after_err = 1'b0, clk_oe_d1 = 1'b0;
  logic       data_oe_d1 = 1'b0, rts_data = 1'b0;

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    clk_oe_d1  <= ps2clk_oe;
    data_oe_d1 <= ps2data_oe;
    err_d1     <= tx_if.tx_error;
    if (tx_if.tx_done) done_cnt <= done_cnt + 1;
    if (tx_if.tx_error) begin
      err_cnt   <= err_cnt + 1;
      err_cyc   <= cyc;
      err_oe    <= {ps2clk_oe, ps2data_oe};
      last_code <= tx_if.err_code;
    end
    if (err_d1) ready_after_err <= tx_if.tx_ready;
    if (ps2clk_oe) run_len <= run_len + 1;
    else run_len <= 0;
    if (clk_oe_d1 && !ps2clk_oe) begin
      inh_len  <= run_len;
      rel_cyc  <= cyc;
      rts_data <= data_oe_d1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic p;
    p = (($countones(b) % 2) == 0);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!tx_if.tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(tx_if.tx_ready), 32'd1);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = b;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    check("busy_on_accept", 32'(tx_if.busy), 32'd1);
  endtask

  // Device: waits for request-to-send, generates 11 clocks, samples on rises.
  task automatic device_frame(input bit ack, input bit glitch, input int abort_after,
                              output logic [10:0] got, output bit ok);
    int n = 0;
    got = '1;
    ok  = 1'b1;
    while (!(ps2clk_oe == 1'b0 && ps2data_oe == 1'b1) && n < INH_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    if (!(ps2clk_oe == 1'b0 && ps2data_oe == 1'b1)) begin
      ok = 1'b0;
      return;
    end
    repeat ($urandom_range(100, 20)) @(negedge clk);
    got[0] = ps2data_in;
    for (int e = 1; e <= 11; e++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (e <= 10) got[4'(e)] = ps2data_in;
      dev_clk = 1'b1;
      if (e == abort_after) return;
      if (glitch && e == 4) begin
        repeat (10) @(negedge clk);
        dev_glitch = 1'b1;
        repeat (3) @(negedge clk);
        dev_glitch = 1'b0;
        repeat (HALF - 13) @(negedge clk);
      end else if (ack && e == 10) begin
        repeat (HALF / 2) @(negedge clk);
        dev_data = 1'b0;
        repeat (HALF / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_evt(input int d0, input int e0, input int limit);
    for (int i = 0; i < limit && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
    check("evt_in_time", 32'((done_cnt != d0) || (err_cnt != e0)), 32'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic run_ok(input logic [7:0] b, input bit glitch);
    logic [10:0] got;
    bit          ok;
    int          d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b);
    device_frame(1'b1, glitch, 0, got, ok);
    check("rts_seen", 32'(ok), 32'd1);
    wait_evt(d0, e0, 300);
    check($sformatf("frame_%02h", b), 32'(got), 32'(frame_of(b)));
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("no_error", 32'(err_cnt - e0), 32'd0);
    check("busy_after", 32'(tx_if.busy), 32'd0);
    check("ready_after", 32'(tx_if.tx_ready), 32'd1);
  endtask

  initial begin
    logic [10:0] got;
    bit          ok;
    int          d0, e0;

    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_ready", 32'(tx_if.tx_ready), 32'd1);
    check("rst_busy", 32'(tx_if.busy), 32'd0);
    check("rst_done", 32'(tx_if.tx_done), 32'd0);
    check("rst_error", 32'(tx_if.tx_error), 32'd0);
    check("rst_code", 32'(tx_if.err_code), 32'd0);
    check("rst_oe", 32'({ps2clk_oe, ps2data_oe}), 32'd0);

    // LED-set command.
    run_ok(8'hED, 1'b0);

    // Enable command; inhibit length and start bit during its last cycle.
    run_ok(8'hF4, 1'b0);
    check("inhibit_len", 32'(inh_len), 32'(INH_CYC));
    check("start_bit_in_inhibit", 32'(rts_data), 32'd1);

    // Device never clocks.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h55);
    wait_evt(d0, e0, START_CYC + INH_CYC + 500);
    check("start_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("start_err_code", 32'(last_code), 32'd1);
    check("start_err_time", 32'(err_cyc - rel_cyc), 32'(START_CYC));
    check("start_err_oe", 32'(err_oe), 32'd0);
    check("start_no_done", 32'(done_cnt - d0), 32'd0);

    // Device withholds ACK; the next request is accepted straight away.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h3C);
    device_frame(1'b0, 1'b0, 0, got, ok);
    wait_evt(d0, e0, 300);
    check("noack_frame", 32'(got), 32'(frame_of(8'h3C)));
    check("noack_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("noack_err_code", 32'(last_code), 32'd3);
    check("noack_err_oe", 32'(err_oe), 32'd0);
    check("ready_after_err", 32'(ready_after_err), 32'd1);
    run_ok(8'($urandom), 1'b0);

    // Short clock glitch mid-frame must not add a bit.
    run_ok(8'($urandom), 1'b1);

    // Random commands.
    for (int i = 0; i < 3; i++) run_ok(8'($urandom), 1'b0);

    // Reset after bit 4 is on the line (bit 4 = 0, so data is being pulled).
    send_byte(8'h0F);
    device_frame(1'b1, 1'b0, 5, got, ok);
    check("pre_rst_data_oe", 32'(ps2data_oe), 32'd1);
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_oe", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
    check("rst_mid_ready", 32'(tx_if.tx_ready), 32'd1);
    check("rst_mid_busy", 32'(tx_if.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (100) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_no_error", 32'(err_cnt - e0), 32'd0);
    check("rst_mid_code", 32'(tx_if.err_code), 32'd0);
    run_ok(8'hFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
